// File: rtl/min_max_finder_param_pkg.sv
// ============================================================================
// Module      : min_max_finder_param_pkg
// Description : Shared state encoding and constants for the parametrised
//               min/max finder family.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package min_max_finder_param_pkg;

    // Width of the one-hot state vector (INI, LOAD, CMx, CMn, DONE)
    localparam int c_STATE_W = 5;

    // One-hot scan states; bit positions match the Qi/Ql/Qcmx/Qcmn/Qd outputs
    typedef enum logic [c_STATE_W-1:0] {
        S_INI  = 5'b00001,
        S_LOAD = 5'b00010,
        S_CMX  = 5'b00100,
        S_CMN  = 5'b01000,
        S_DONE = 5'b10000
    } state_t;

endpackage

`default_nettype wire

// File: rtl/min_max_finder_param_cmp.sv
// ============================================================================
// Module      : min_max_finder_param_cmp
// Description : Combinational greater-than / less-than of two WIDTH-bit
//               words, unsigned or two's-complement per SIGNED_CMP.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module min_max_finder_param_cmp #(
    parameter int WIDTH      = 8,
    parameter int SIGNED_CMP = 0
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_gt,
    output logic             o_lt
);

    generate
        if (SIGNED_CMP != 0) begin : g_signed
            // Two's-complement ordering
            assign o_gt = ($signed(i_a) > $signed(i_b));
            assign o_lt = ($signed(i_a) < $signed(i_b));
        end else begin : g_unsigned
            // Plain magnitude ordering
            assign o_gt = (i_a > i_b);
            assign o_lt = (i_a < i_b);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/min_max_finder_param.sv
// ============================================================================
// Module      : min_max_finder_param
// Description : Scans DEPTH words of WIDTH bits held in an internal register
//               array and reports the maximum and minimum. A write port loads
//               the array while idle; a Start pulse launches a scan of exactly
//               DEPTH clocks (1 LOAD + DEPTH-1 compares). The CMx/CMn states
//               record which extreme was updated last.
//               Optional feature macro: MINMAX_INDEX_EN adds Max_idx/Min_idx
//               (first occurrence of each extreme).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module min_max_finder_param
    import min_max_finder_param_pkg::*;
#(
    parameter  int WIDTH      = 8,
    parameter  int DEPTH      = 16,
    parameter  int SIGNED_CMP = 0,
    localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             Wr_en,
    input  logic [AW-1:0]    Wr_addr,
    input  logic [WIDTH-1:0] Wr_data,
    output logic [WIDTH-1:0] Max,
    output logic [WIDTH-1:0] Min,
`ifdef MINMAX_INDEX_EN
    output logic [AW-1:0]    Max_idx,
    output logic [AW-1:0]    Min_idx,
`endif
    output logic             Qi,
    output logic             Ql,
    output logic             Qcmx,
    output logic             Qcmn,
    output logic             Qd
);

    // Index of the final word; the scan ends on the cycle that compares it
    localparam logic [AW-1:0] c_LAST  = AW'(DEPTH - 1);
    // Depth widened by one bit so out-of-range write addresses can be rejected
    localparam logic [AW:0]   c_DEPTH = (AW + 1)'(DEPTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_max;
    logic [WIDTH-1:0] r_min;
    logic [AW-1:0]    r_idx;
`ifdef MINMAX_INDEX_EN
    logic [AW-1:0]    r_max_idx;
    logic [AW-1:0]    r_min_idx;
`endif

    logic [WIDTH-1:0] w_cur;
    logic [WIDTH-1:0] w_first;
    logic             w_idle;
    logic             w_wr_ok;
    logic             w_gt_max;
    logic             w_lt_max;
    logic             w_gt_min;
    logic             w_lt_min;
    logic             w_unused;

    assign w_cur    = r_mem[r_idx];
    assign w_first  = r_mem[0];
    assign w_idle   = (r_state == S_INI) || (r_state == S_DONE);
    assign w_wr_ok  = Wr_en && w_idle && ({1'b0, Wr_addr} < c_DEPTH);
    // Only "above Max" and "below Min" drive the datapath
    assign w_unused = w_lt_max ^ w_gt_min;

    min_max_finder_param_cmp #(
        .WIDTH      (WIDTH),
        .SIGNED_CMP (SIGNED_CMP)
    ) u_cmp_max (
        .i_a  (w_cur),
        .i_b  (r_max),
        .o_gt (w_gt_max),
        .o_lt (w_lt_max)
    );

    min_max_finder_param_cmp #(
        .WIDTH      (WIDTH),
        .SIGNED_CMP (SIGNED_CMP)
    ) u_cmp_min (
        .i_a  (w_cur),
        .i_b  (r_min),
        .o_gt (w_gt_min),
        .o_lt (w_lt_min)
    );

    // Array load: only while idle, so a scan always sees a stable array; not reset
    always_ff @(posedge Clk) begin
        if (w_wr_ok) begin
            r_mem[Wr_addr] <= Wr_data;
        end
    end

    // Scan controller: state, running extremes, scan pointer and indices
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state   <= S_INI;
            r_max     <= '0;
            r_min     <= '0;
            r_idx     <= '0;
`ifdef MINMAX_INDEX_EN
            r_max_idx <= '0;
            r_min_idx <= '0;
`endif
        end else begin
            case (r_state)
                S_INI, S_DONE: begin
                    if (Start) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_max   <= w_first;
                    r_min   <= w_first;
                    r_idx   <= AW'(1);
`ifdef MINMAX_INDEX_EN
                    r_max_idx <= '0;
                    r_min_idx <= '0;
`endif
                    r_state <= S_CMX;
                end
                S_CMX: begin
                    if (w_gt_max) begin
                        r_max <= w_cur;
`ifdef MINMAX_INDEX_EN
                        r_max_idx <= r_idx;
`endif
                    end else if (w_lt_min) begin
                        r_min   <= w_cur;
`ifdef MINMAX_INDEX_EN
                        r_min_idx <= r_idx;
`endif
                        r_state <= S_CMN;
                    end
                    // Final word overrides the flag transition; pointer parks at the end
                    if (r_idx == c_LAST) begin
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + AW'(1);
                    end
                end
                S_CMN: begin
                    if (w_lt_min) begin
                        r_min <= w_cur;
`ifdef MINMAX_INDEX_EN
                        r_min_idx <= r_idx;
`endif
                    end else if (w_gt_max) begin
                        r_max   <= w_cur;
`ifdef MINMAX_INDEX_EN
                        r_max_idx <= r_idx;
`endif
                        r_state <= S_CMX;
                    end
                    if (r_idx == c_LAST) begin
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + AW'(1);
                    end
                end
                default: begin
                    r_state <= S_INI;
                end
            endcase
        end
    end

    assign Max  = r_max;
    assign Min  = r_min;
`ifdef MINMAX_INDEX_EN
    assign Max_idx = r_max_idx;
    assign Min_idx = r_min_idx;
`endif
    assign Qi   = (r_state == S_INI);
    assign Ql   = (r_state == S_LOAD);
    assign Qcmx = (r_state == S_CMX);
    assign Qcmn = (r_state == S_CMN);
    assign Qd   = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_min_max_finder_param.sv
// ============================================================================
// Module      : tb_min_max_finder_param
// Description : Scoreboard bench for min_max_finder_param. Stimulus pushes the
//               expected result of each scan; monitors pop and compare on each
//               rising Qd. Three instances: 8x16 unsigned, 8x16 signed, 12x4.
//               Index checks are active when MINMAX_INDEX_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_min_max_finder_param;

    typedef struct {
        logic [15:0] mx;
        logic [15:0] mn;
        int          mxi;
        int          mni;
        int          done_cyc;
    } exp_t;

    logic        Clk_tb;
    logic        Reset_n;
    logic        Start_u, Start_s, Start4;
    logic        Wr_en, Wr_en4;
    logic [3:0]  Wr_addr;
    logic [7:0]  Wr_data;
    logic [1:0]  Wr_addr4;
    logic [11:0] Wr_data4;

    logic [7:0]  Max_u, Min_u, Max_s, Min_s;
    logic [11:0] Max_4, Min_4;
    logic        Qi_u, Ql_u, Qcmx_u, Qcmn_u, Qd_u;
    logic        Qi_s, Ql_s, Qcmx_s, Qcmn_s, Qd_s;
    logic        Qi_4, Ql_4, Qcmx_4, Qcmn_4, Qd_4;
`ifdef MINMAX_INDEX_EN
    logic [3:0]  Max_idx_u, Min_idx_u, Max_idx_s, Min_idx_s;
    logic [1:0]  Max_idx_4, Min_idx_4;
`endif

    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    exp_t q_u[$], q_s[$], q_4[$];
    exp_t e_u, e_s, e_4;
    logic qd_u_prev = 1'b0, qd_s_prev = 1'b0, qd_4_prev = 1'b0;

    logic [7:0] t1 [16] = '{8'h3B, 8'h9A, 8'h64, 8'hF4, 8'h90, 8'h83, 8'h23, 8'hF4,
                            8'hF4, 8'h85, 8'h02, 8'h99, 8'h02, 8'h02, 8'h84, 8'hF5};

    min_max_finder_param #(.WIDTH(8), .DEPTH(16), .SIGNED_CMP(0)) u_dut (
        .Clk(Clk_tb), .Reset_n(Reset_n), .Start(Start_u), .Wr_en(Wr_en),
        .Wr_addr(Wr_addr), .Wr_data(Wr_data), .Max(Max_u), .Min(Min_u),
`ifdef MINMAX_INDEX_EN
        .Max_idx(Max_idx_u), .Min_idx(Min_idx_u),
`endif
        .Qi(Qi_u), .Ql(Ql_u), .Qcmx(Qcmx_u), .Qcmn(Qcmn_u), .Qd(Qd_u)
    );

    min_max_finder_param #(.WIDTH(8), .DEPTH(16), .SIGNED_CMP(1)) u_dut_s (
        .Clk(Clk_tb), .Reset_n(Reset_n), .Start(Start_s), .Wr_en(Wr_en),
        .Wr_addr(Wr_addr), .Wr_data(Wr_data), .Max(Max_s), .Min(Min_s),
`ifdef MINMAX_INDEX_EN
        .Max_idx(Max_idx_s), .Min_idx(Min_idx_s),
`endif
        .Qi(Qi_s), .Ql(Ql_s), .Qcmx(Qcmx_s), .Qcmn(Qcmn_s), .Qd(Qd_s)
    );

    min_max_finder_param #(.WIDTH(12), .DEPTH(4), .SIGNED_CMP(0)) u_dut4 (
        .Clk(Clk_tb), .Reset_n(Reset_n), .Start(Start4), .Wr_en(Wr_en4),
        .Wr_addr(Wr_addr4), .Wr_data(Wr_data4), .Max(Max_4), .Min(Min_4),
`ifdef MINMAX_INDEX_EN
        .Max_idx(Max_idx_4), .Min_idx(Min_idx_4),
`endif
        .Qi(Qi_4), .Ql(Ql_4), .Qcmx(Qcmx_4), .Qcmn(Qcmn_4), .Qd(Qd_4)
    );

    initial Clk_tb = 1'b0;
    always #5 Clk_tb = ~Clk_tb;

    always @(posedge Clk_tb) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic cmp_result(input string tag, input exp_t e,
                              input logic [15:0] mx, input logic [15:0] mn);
        check({tag, "_max"}, 32'(mx), 32'(e.mx));
        check({tag, "_min"}, 32'(mn), 32'(e.mn));
        check({tag, "_done_latency"}, cyc, e.done_cyc);
    endtask

    task automatic unexpected(input string tag);
        n_checks++;
        n_err++;
        $display("FAIL %s_unexpected_done: got Qd rise, expected no pending scan", tag);
    endtask

    function automatic exp_t mk(input logic [15:0] mx, input logic [15:0] mn,
                                input int mxi, input int mni, input int depth);
        exp_t e;
        e.mx = mx; e.mn = mn; e.mxi = mxi; e.mni = mni;
        // Start is driven now and sampled at the next posedge; Qd rises depth edges later
        e.done_cyc = cyc + 1 + depth;
        return e;
    endfunction

    // Monitors: compare on each rising Qd
    always @(negedge Clk_tb) begin
        if (Qd_u && !qd_u_prev) begin
            if (q_u.size() == 0) unexpected("u");
            else begin
                e_u = q_u.pop_front();
                cmp_result("u", e_u, 16'(Max_u), 16'(Min_u));
`ifdef MINMAX_INDEX_EN
                check("u_max_idx", 32'(Max_idx_u), e_u.mxi);
                check("u_min_idx", 32'(Min_idx_u), e_u.mni);
`endif
            end
        end
        qd_u_prev = Qd_u;
    end

    always @(negedge Clk_tb) begin
        if (Qd_s && !qd_s_prev) begin
            if (q_s.size() == 0) unexpected("s");
            else begin
                e_s = q_s.pop_front();
                cmp_result("s", e_s, 16'(Max_s), 16'(Min_s));
`ifdef MINMAX_INDEX_EN
                check("s_max_idx", 32'(Max_idx_s), e_s.mxi);
                check("s_min_idx", 32'(Min_idx_s), e_s.mni);
`endif
            end
        end
        qd_s_prev = Qd_s;
    end

    always @(negedge Clk_tb) begin
        if (Qd_4 && !qd_4_prev) begin
            if (q_4.size() == 0) unexpected("d4");
            else begin
                e_4 = q_4.pop_front();
                cmp_result("d4", e_4, 16'(Max_4), 16'(Min_4));
`ifdef MINMAX_INDEX_EN
                check("d4_max_idx", 32'(Max_idx_4), e_4.mxi);
                check("d4_min_idx", 32'(Min_idx_4), e_4.mni);
`endif
            end
        end
        qd_4_prev = Qd_4;
    end

    task automatic wr(input int a, input logic [7:0] d);
        Wr_en = 1'b1; Wr_addr = 4'(a); Wr_data = d;
        @(negedge Clk_tb);
        Wr_en = 1'b0;
    endtask

    task automatic pulse_u();
        Start_u = 1'b1;
        @(negedge Clk_tb);
        Start_u = 1'b0;
    endtask

    initial begin
        Reset_n = 1'b0; Start_u = 1'b0; Start_s = 1'b0; Start4 = 1'b0;
        Wr_en = 1'b0; Wr_addr = '0; Wr_data = '0;
        Wr_en4 = 1'b0; Wr_addr4 = '0; Wr_data4 = '0;
        repeat (3) @(negedge Clk_tb);

        // Reset state
        check("rst_qi", 32'(Qi_u), 1);
        check("rst_ql", 32'(Ql_u), 0);
        check("rst_qcmx", 32'(Qcmx_u), 0);
        check("rst_qcmn", 32'(Qcmn_u), 0);
        check("rst_qd", 32'(Qd_u), 0);
        check("rst_max", 32'(Max_u), 0);
        check("rst_min", 32'(Min_u), 0);
        check("rst_qi_d4", 32'(Qi_4), 1);
        Reset_n = 1'b1;
        @(negedge Clk_tb);

        // Mixed data, unsigned and signed compare
        for (int i = 0; i < 16; i++) wr(i, t1[i]);
        q_u.push_back(mk(16'hF5, 16'h02, 15, 10, 16));
        q_s.push_back(mk(16'h64, 16'h83, 2, 5, 16));
        Start_u = 1'b1; Start_s = 1'b1;
        @(negedge Clk_tb);
        Start_u = 1'b0; Start_s = 1'b0;
        repeat (20) @(negedge Clk_tb);

        // Reset mid-scan with I=7 (words 0..6 compared), then clean rescan
        pulse_u();
        repeat (7) @(negedge Clk_tb);
        check("mid_qcmn", 32'(Qcmn_u), 1);
        check("mid_max", 32'(Max_u), 32'h F4);
        check("mid_min", 32'(Min_u), 32'h 23);
        Reset_n = 1'b0;
        @(negedge Clk_tb);
        check("abort_qi", 32'(Qi_u), 1);
        check("abort_max", 32'(Max_u), 0);
        check("abort_min", 32'(Min_u), 0);
        Reset_n = 1'b1;
        @(negedge Clk_tb);
        q_u.push_back(mk(16'hF5, 16'h02, 15, 10, 16));
        pulse_u();
        repeat (20) @(negedge Clk_tb);

        // Write during scan is ignored; busy Start is not queued
        q_u.push_back(mk(16'hF5, 16'h02, 15, 10, 16));
        pulse_u();
        repeat (3) @(negedge Clk_tb);
        wr(3, 8'h00);
        pulse_u();
        repeat (16) @(negedge Clk_tb);
        check("done_hold_qd", 32'(Qd_u), 1);

        // Restart from DONE with a same-cycle write of M[0]
        q_u.push_back(mk(16'hFF, 16'h02, 0, 10, 16));
        Wr_en = 1'b1; Wr_addr = 4'd0; Wr_data = 8'hFF; Start_u = 1'b1;
        @(negedge Clk_tb);
        Wr_en = 1'b0; Start_u = 1'b0;
        repeat (20) @(negedge Clk_tb);

        // Ascending: ends from CMx
        for (int i = 0; i < 16; i++) wr(i, 8'(8'h73 + i));
        q_u.push_back(mk(16'h82, 16'h73, 15, 0, 16));
        pulse_u();
        repeat (20) @(negedge Clk_tb);

        // Descending: ends from CMn
        for (int i = 0; i < 16; i++) wr(i, 8'(8'h82 - i));
        q_u.push_back(mk(16'h82, 16'h73, 0, 15, 16));
        pulse_u();
        repeat (20) @(negedge Clk_tb);

        // 12-bit x 4 instance, all words equal
        for (int i = 0; i < 4; i++) begin
            Wr_en4 = 1'b1; Wr_addr4 = 2'(i); Wr_data4 = 12'h7FF;
            @(negedge Clk_tb);
        end
        Wr_en4 = 1'b0;
        q_4.push_back(mk(16'h7FF, 16'h7FF, 0, 0, 4));
        Start4 = 1'b1;
        @(negedge Clk_tb);
        Start4 = 1'b0;
        repeat (10) @(negedge Clk_tb);

        // Every expected scan must have completed
        check("pending_u", q_u.size(), 0);
        check("pending_s", q_s.size(), 0);
        check("pending_d4", q_4.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
